// File: rtl/median_filter_engine_p.sv
// 3x3 rank filter (median/min/max) over an IMG_W x IMG_H frame, one pixel per 20 cycles.
// Window is fetched with clamped addresses, then sorted in place by odd-even transposition.
//   state   | meaning
//   S_IDLE  | waiting for ready, outputs quiet
//   S_FETCH | 10 cycles: issue 9 window reads, capture data one cycle later
//   S_SORT  | 9 cycles: odd-even transposition passes on the window
//   S_WRITE | 1 cycle: wen with selected rank at address p
//   S_DONE  | 1 cycle: done pulse, busy already low
module median_filter_engine_p #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [1:0]        mode,
  input  logic              border,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [PIX_W-1:0]  idata,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  data_wr,
  output logic              wen,
  output logic              done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_W:0] LAST_P  = (ADDR_W+1)'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0]   COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0]   ROW_MAX = RW'(IMG_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SORT, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   p_q, p_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [1:0]        mode_q, mode_d;
  logic              border_q, border_d;
  logic              busy_q, busy_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic [PIX_W-1:0]  win_q [9];
  logic [PIX_W-1:0]  win_d [9];

  // Window element j: row offset j/3-1, column offset j%3-1.
  function automatic logic out_of_bounds(input int j, input logic [RW-1:0] r, input logic [CW-1:0] c);
    return ((j / 3 == 0) && (r == '0)) || ((j / 3 == 2) && (r == ROW_MAX)) ||
           ((j % 3 == 0) && (c == '0)) || ((j % 3 == 2) && (c == COL_MAX));
  endfunction

  function automatic logic [ADDR_W-1:0] elem_addr(input int j, input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic [RW-1:0] rr;
    logic [CW-1:0] cc;
    rr = r;
    cc = c;
    if (j / 3 == 0 && r != '0)      rr = r - RW'(1);
    if (j / 3 == 2 && r != ROW_MAX) rr = r + RW'(1);
    if (j % 3 == 0 && c != '0)      cc = c - CW'(1);
    if (j % 3 == 2 && c != COL_MAX) cc = c + CW'(1);
    return ADDR_W'(rr) * ADDR_W'(IMG_W) + ADDR_W'(cc);
  endfunction

  assign iaddr   = (state_q == S_FETCH && cnt_q <= 4'd8) ? elem_addr(int'(cnt_q), row_q, col_q) : '0;
  assign busy    = busy_q;
  assign wen     = wen_q;
  assign done    = done_q;
  assign addr    = addr_q;
  assign data_wr = data_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    row_d    = row_q;
    col_d    = col_q;
    mode_d   = mode_q;
    border_d = border_q;
    busy_d   = busy_q;
    wen_d    = 1'b0;
    done_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    win_d    = win_q;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d  = S_FETCH;
          mode_d   = mode;
          border_d = border;
          busy_d   = 1'b1;
          p_d      = '0;
          row_d    = '0;
          col_d    = '0;
          cnt_d    = '0;
        end
      end
      S_FETCH: begin
        // Read data lags the address by one cycle, so cycle k lands element k-1.
        for (int j = 0; j < 9; j++)
          if (cnt_q == 4'(j + 1))
            win_d[j] = (!border_q && out_of_bounds(j, row_q, col_q)) ? '0 : idata;
        if (cnt_q == 4'd9) begin
          cnt_d   = '0;
          state_d = S_SORT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SORT: begin
        for (int i = 0; i < 8; i++)
          if ((i % 2) == int'(cnt_q[0]) && win_q[i] > win_q[i+1]) begin
            win_d[i]   = win_q[i+1];
            win_d[i+1] = win_q[i];
          end
        if (cnt_q == 4'd8) begin
          cnt_d   = '0;
          state_d = S_WRITE;
          wen_d   = 1'b1;
          addr_d  = p_q[ADDR_W-1:0];
          case (mode_q)
            2'b01:   data_d = win_d[0];
            2'b10:   data_d = win_d[8];
            default: data_d = win_d[4];
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WRITE: begin
        if (p_q == LAST_P) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
          p_d     = p_q + (ADDR_W+1)'(1);
          if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      mode_q   <= '0;
      border_q <= 1'b0;
      busy_q   <= 1'b0;
      wen_q    <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      row_q    <= row_d;
      col_q    <= col_d;
      mode_q   <= mode_d;
      border_q <= border_d;
      busy_q   <= busy_d;
      wen_q    <= wen_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: tb/tb_median_filter_engine_p.sv
// Bench for median_filter_engine_p on a 4x4 image: table vectors, timing/handshake,
// mid-frame reset and random frames against a sort-based reference model.
module tb_median_filter_engine_p;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk;
  logic       reset;
  logic       ready;
  logic [1:0] mode;
  logic       border;
  logic       busy;
  logic [3:0] iaddr;
  logic [7:0] idata;
  logic [3:0] addr;
  logic [7:0] data_wr;
  logic       wen;
  logic       done;

  median_filter_engine_p #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .ready(ready), .mode(mode), .border(border),
    .busy(busy), .iaddr(iaddr), .idata(idata), .addr(addr), .data_wr(data_wr),
    .wen(wen), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [N];
  always @(posedge clk) idata <= mem[iaddr];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] got   [N];
  bit         got_v [N];

  typedef struct {
    logic [1:0] mode;
    logic       border;
    int         img;
    int         pix;
    int         exp;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_image(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       mem[i] = 8'(10 * i);
        1:       mem[i] = (i == 5) ? 8'd255 : 8'd50;
        default: mem[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Reference: gather the 3x3 neighbourhood, fully sort it, pick the requested rank.
  function automatic int ref_pix(input int p, input logic [1:0] m, input logic b);
    int w [9];
    int r, c, k, rr, cc, t;
    r = p / W;
    c = p % W;
    k = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        rr = r + dy;
        cc = c + dx;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
          if (b) begin
            rr = (rr < 0) ? 0 : (rr >= H) ? H - 1 : rr;
            cc = (cc < 0) ? 0 : (cc >= W) ? W - 1 : cc;
            w[k] = int'(mem[rr * W + cc]);
          end else begin
            w[k] = 0;
          end
        end else begin
          w[k] = int'(mem[rr * W + cc]);
        end
        k++;
      end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (w[j] > w[j+1]) begin
          t = w[j]; w[j] = w[j+1]; w[j+1] = t;
        end
    case (m)
      2'b01:   return w[0];
      2'b10:   return w[8];
      default: return w[4];
    endcase
  endfunction

  task automatic run_frame(input logic [1:0] m, input logic b, input bit hold);
    int  n, first_wen, done_n, wcount, bad_order, dbl;
    bit  started, prev_wen;
    logic busy_at_done;
    for (int i = 0; i < N; i++) got_v[i] = 1'b0;
    @(negedge clk);
    mode   = m;
    border = b;
    ready  = 1'b1;
    started = 1'b0;
    for (int i = 0; i < 5 && !started; i++) begin
      @(negedge clk);
      if (busy) started = 1'b1;
    end
    check("busy_rises", 32'(started), 32'd1);
    if (!started) begin
      ready = 1'b0;
      return;
    end
    if (!hold) ready = 1'b0;
    mode   = ~m;
    border = ~b;
    n = 0; first_wen = -1; done_n = -1; wcount = 0; bad_order = 0; dbl = 0;
    prev_wen = 1'b0; busy_at_done = 1'b1;
    while (done_n < 0 && n < 400) begin
      if (wen) begin
        if (prev_wen) dbl++;
        if (first_wen < 0) first_wen = n;
        if (int'(addr) != wcount) bad_order++;
        got[addr]   = data_wr;
        got_v[addr] = 1'b1;
        wcount++;
      end
      prev_wen = wen;
      if (done) begin
        done_n = n;
        busy_at_done = busy;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check("first_wen_latency", 32'(first_wen), 32'd19);
    check("done_latency", 32'(done_n), 32'(N * 20));
    check("write_count", 32'(wcount), 32'(N));
    check("addr_order_errors", 32'(bad_order), 32'd0);
    check("back_to_back_wen", 32'(dbl), 32'd0);
    check("busy_low_at_done", 32'(busy_at_done), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("no_restart_in_done", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input logic [1:0] m, input logic b, input string tag);
    for (int p = 0; p < N; p++)
      check($sformatf("%s_pix%0d", tag, p), got_v[p] ? 32'(got[p]) : 32'hFFFF_FFFF,
            32'(ref_pix(p, m, b)));
  endtask

  int wen_seen;
  int busy_seen;

  initial begin
    tbl[0] = '{2'd0, 1'b0, 0, 5, 50};
    tbl[1] = '{2'd0, 1'b0, 0, 0, 0};
    tbl[2] = '{2'd0, 1'b1, 0, 0, 10};
    tbl[3] = '{2'd0, 1'b1, 0, 5, 50};
    tbl[4] = '{2'd2, 1'b0, 0, 15, 150};
    tbl[5] = '{2'd1, 1'b0, 0, 15, 0};
    tbl[6] = '{2'd1, 1'b1, 0, 15, 100};
    tbl[7] = '{2'd0, 1'b0, 1, 5, 50};
    tbl[8] = '{2'd3, 1'b0, 1, 5, 50};

    reset = 1'b0; ready = 1'b0; mode = 2'd0; border = 1'b0;
    load_image(0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_iaddr", 32'(iaddr), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data_wr), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      load_image(tbl[v].img);
      run_frame(tbl[v].mode, tbl[v].border, 1'b0);
      check($sformatf("vec%0d_pix%0d", v, tbl[v].pix),
            got_v[tbl[v].pix] ? 32'(got[tbl[v].pix]) : 32'hFFFF_FFFF, 32'(tbl[v].exp));
      check_frame(tbl[v].mode, tbl[v].border, $sformatf("vec%0d", v));
    end

    // Held ready: the DONE cycle must not restart, the following IDLE cycle must.
    load_image(0);
    run_frame(2'd0, 1'b0, 1'b1);
    check_frame(2'd0, 1'b0, "hold");
    @(negedge clk);
    check("restart_from_idle", 32'(busy), 32'd1);
    ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset during SORT of pixel 3.
    load_image(0);
    mode = 2'd0; border = 1'b0; ready = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 5 && busy_seen == 0; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("mid_busy_rises", 32'(busy_seen), 32'd1);
    ready = 1'b0;
    for (int i = 0; i < 73; i++) @(negedge clk);
    check("mid_pre_addr", 32'(addr), 32'd2);
    check("mid_pre_data", 32'(data_wr), 32'(ref_pix(2, 2'd0, 1'b0)));
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_wen", 32'(wen), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_iaddr", 32'(iaddr), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_data", 32'(data_wr), 32'd0);
    wen_seen = 0; busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wen) wen_seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wen) wen_seen++;
      if (busy) busy_seen++;
    end
    check("mid_no_wen_after_reset", 32'(wen_seen), 32'd0);
    check("mid_needs_new_ready", 32'(busy_seen), 32'd0);
    run_frame(2'd0, 1'b0, 1'b0);
    check_frame(2'd0, 1'b0, "after_rst");

    for (int f = 0; f < 5; f++) begin
      logic [1:0] rm;
      logic       rb;
      rm = 2'($urandom_range(0, 3));
      rb = 1'($urandom_range(0, 1));
      load_image(2);
      run_frame(rm, rb, 1'b0);
      check_frame(rm, rb, $sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
